locked_request_mux: RTL
=======================

Name: locked_request_mux

Overview:
- Downstream consumer of the fixed-priority grant.
- Takes NUM_PORTS valid/ready request streams of multi-beat bursts and selects one port by fixed priority; LSB has the highest priority.
- Holds the grant for the whole burst until the last beat is accepted, then forwards beats through a one-deep output register to a single shared consumer (e.g. unified buffer or weight FIFO write port).
- Prevents a higher-priority port from splitting another port's burst.

Parameters:
- NUM_PORTS, 2, number of requesting ports (>=1).
- DATA_WIDTH, 32, payload bits per beat.
- PORT_W, $clog2(NUM_PORTS) (min 1), width of port-index output; derived, not overridden.
- MAX_BURST, 16, beat limit per burst; used only with the optional feature.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_PORTS  per-port beat valid.
- req_data  in  NUM_PORTS*DATA_WIDTH  per-port payload; port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_PORTS  per-port last beat of burst.
- req_ready  out  NUM_PORTS  per-port beat accepted when valid&ready.
- out_valid  out  1  output register holds a beat.
- out_data  out  DATA_WIDTH  registered payload.
- out_last  out  1  registered last flag.
- out_port  out  PORT_W  index of the port that produced the beat.
- out_ready  in  1  consumer accepts when out_valid&out_ready.
- burst_err  out  1  one-cycle pulse on forced release (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (rst=1 at clock edge):
  - State=IDLE; out_valid=0, out_data=0, out_last=0, out_port=0, burst_err=0.
  - Beat counter=0.
  - req_ready all 0 while rst is high.
- slot_free = !out_valid || out_ready. The output register refills on the same cycle it drains, giving full throughput of 1 beat/cycle.
- IDLE:
  - grant = lowest-index i with req_valid[i]=1 (one-hot, combinational).
  - req_ready = grant & {NUM_PORTS{slot_free}}.
  - On acceptance, capture data/last/index into the output register.
  - If the beat is not last: lock_port=i, go LOCKED.
  - If last (single-beat burst): stay IDLE.
  - No valid requests: req_ready=0, nothing captured.
- LOCKED:
  - Only req_ready[lock_port] may be 1, equal to slot_free; all other ports get 0 regardless of priority.
  - Acceptance with req_last=1 returns to IDLE; the next arbitration happens the following cycle.
  - lock_port valid low: wait indefinitely, hold lock.
- Latency: beat accepted at edge N appears on out_* after edge N (registered, 1 cycle). out_* remain stable while out_valid && !out_ready.
- Ordering: beats of one burst are contiguous on the output; no interleaving between ports.
- Simultaneous: out_ready drain and new capture in the same cycle are legal; out_valid stays 1.
- Reset mid-burst: lock dropped and the output register cleared. The in-flight beat is lost; upstream is responsible for restart.
- Beat counter: counts accepted beats in the current burst; cleared on the last beat and on returning to IDLE. Width $clog2(MAX_BURST+1).
- Requesters must keep valid/data stable until ready (AXI-style); the block does not check this.

Optional Feature:
- Macro LOCKED_MUX_MAX_BURST_EN.
- Defined:
  - If a locked burst accepts its MAX_BURST-th beat with req_last=0, that beat is forwarded with out_last forced to 1.
  - burst_err pulses high for 1 cycle, coincident with that beat appearing on out_*.
  - State returns to IDLE, so a starving requester can win.
  - Remaining beats of the broken burst are arbitrated as a new burst.
- Undefined: no limit; the counter may be omitted; burst_err constant 0; out_last always equals captured req_last.

Test Plan:
- Reset with req_valid=2'b11 held -> req_ready=0, out_valid=0 during reset. First cycle after reset: req_ready=2'b01, out_port=0 next cycle.
- NUM_PORTS=2: port1 starts a 4-beat burst (data 0x10..0x13); port0 raises valid at beat 2 -> out sees 0x10,0x11,0x12,0x13 with out_port=1, then port0's beat. req_ready[0]=0 throughout the lock.
- Backpressure: out_ready=0 for 3 cycles mid-burst -> out_data/out_last/out_port stable; req_ready=0 at the locked port. When out_ready rises, 1 beat/cycle resumes with no beat lost or duplicated.
- Single-beat bursts, both ports valid continuously with last=1 -> port0 wins every cycle and port1 starves. Drop port0 valid -> port1 granted the same cycle.
- Reset asserted while LOCKED on port1 mid-burst -> next cycle out_valid=0, state IDLE. Port0 valid is granted immediately after reset.
- With LOCKED_MUX_MAX_BURST_EN, MAX_BURST=4, port1 sends 6 beats with last only on beat 6:
  - Beat 4 is output with out_last=1 and burst_err=1 for 1 cycle.
  - Port0 pending at that point -> port0 granted next.
  - Beats 5-6 follow as a new burst.
  - Without the macro: 6 contiguous beats, burst_err=0.

Source files
------------

// File: rtl/locked_request_mux_if.sv
// rtl/locked_request_mux_if.sv - request and output handshake bundle for locked_request_mux
interface locked_request_mux_if #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 32
);
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]            req_valid;
    logic [NUM_PORTS*DATA_WIDTH-1:0] req_data;
    logic [NUM_PORTS-1:0]            req_last;
    logic [NUM_PORTS-1:0]            req_ready;
    logic                            out_valid;
    logic [DATA_WIDTH-1:0]           out_data;
    logic                            out_last;
    logic [PORT_W-1:0]               out_port;
    logic                            out_ready;
    logic                            burst_err;

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last, out_port, burst_err
    );

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last, out_port, burst_err
    );
endinterface

// File: rtl/locked_request_mux.sv
// rtl/locked_request_mux.sv - fixed-priority burst-locked request mux with one-deep output register
// Optional burst limit with forced release: LOCKED_MUX_MAX_BURST_EN
module locked_request_mux #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input logic clk,
    input logic rst,
    locked_request_mux_if.slave bus
);
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    if (NUM_PORTS < 1 || MAX_BURST < 1) begin : g_bad_cfg
        $error("locked_request_mux: NUM_PORTS and MAX_BURST must be >= 1");
    end

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state_q, state_d;
    logic [PORT_W-1:0]     lock_port_q, lock_port_d;
    logic [PORT_W-1:0]     sel_port;
    logic [NUM_PORTS-1:0]  ready;
    logic                  slot_free;
    logic                  accept;
    logic                  sel_last;
    logic                  force_release;
    logic                  last_eff;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_last_q;
    logic [PORT_W-1:0]     out_port_q;

    // Output register can take a new beat whenever it is empty or draining this cycle.
    assign slot_free = !out_valid_q || bus.out_ready;

    always_comb begin
        ready    = '0;
        sel_port = lock_port_q;
        if (state_q == IDLE) begin
            sel_port = '0;
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (bus.req_valid[i]) sel_port = PORT_W'(i);
            end
            ready[sel_port] = slot_free && bus.req_valid[sel_port];
        end else begin
            ready[sel_port] = slot_free;
        end
        if (rst) ready = '0;
        accept = bus.req_valid[sel_port] && ready[sel_port];
    end

    assign sel_last = bus.req_last[sel_port];
    assign sel_data = bus.req_data[int'(sel_port)*DATA_WIDTH +: DATA_WIDTH];
    assign last_eff = sel_last || force_release;

    always_comb begin
        state_d     = state_q;
        lock_port_d = lock_port_q;
        if (accept) begin
            state_d     = last_eff ? IDLE : LOCKED;
            lock_port_d = sel_port;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lock_port_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_port_q  <= '0;
        end else begin
            state_q     <= state_d;
            lock_port_q <= lock_port_d;
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= sel_data;
                out_last_q  <= last_eff;
                out_port_q  <= sel_port;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef LOCKED_MUX_MAX_BURST_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [CNT_W-1:0] beat_cnt_q;
    logic             burst_err_q;

    // The MAX_BURST-th beat of a burst that still has no last flag ends the burst early.
    assign force_release = accept && !sel_last && (beat_cnt_q == CNT_W'(MAX_BURST - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q  <= '0;
            burst_err_q <= 1'b0;
        end else begin
            burst_err_q <= force_release;
            if (accept) beat_cnt_q <= last_eff ? '0 : beat_cnt_q + 1'b1;
        end
    end

    assign bus.burst_err = burst_err_q;
`else
    assign force_release = 1'b0;
    assign bus.burst_err = 1'b0;
`endif

    assign bus.req_ready = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_port  = out_port_q;
endmodule
